// File: rtl/uart_alu_bridge.sv
// ---------------------------------------------------------------------------
// uart_alu_bridge
//   Pulls three-byte frames (operand A, operand B, opcode) from an RX FIFO,
//   computes one ALU result and pushes that single byte into a TX FIFO.
//   If a frame stalls partway, it is dropped after TIMEOUT_LIMIT idle cycles.
//
// Ports
//   i_clk           : clock, rising edge
//   i_reset         : synchronous active-high reset
//   i_rx_empty      : RX FIFO empty flag
//   i_data_to_read  : RX FIFO head byte (valid while i_rx_empty=0)
//   o_read_uart     : one-cycle RX pop strobe
//   i_tx_full       : TX FIFO full flag
//   o_write_uart    : one-cycle TX push strobe
//   o_data_to_write : result byte (registered)
//   o_busy          : high whenever the bridge is not waiting for operand A
//   o_op_error      : pulse when an unsupported opcode executes
//   o_timeout       : pulse when a partial frame is discarded
// ---------------------------------------------------------------------------
module uart_alu_bridge #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_LIMIT = 1000000,
    parameter int NB_TIMEOUT    = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_data_to_read,
    output logic               o_read_uart,
    input  logic               i_tx_full,
    output logic               o_write_uart,
    output logic [NB_DATA-1:0] o_data_to_write,
    output logic               o_busy,
    output logic               o_op_error,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_SEND   = 3'd4
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);

    localparam logic [NB_TIMEOUT-1:0] TMO_MAX = NB_TIMEOUT'(TIMEOUT_LIMIT - 1);
    localparam logic [NB_TIMEOUT-1:0] TMO_ONE = NB_TIMEOUT'(1);

    state_t              state_r;
    state_t              state_next_s;
    logic [NB_DATA-1:0]  a_r;
    logic [NB_DATA-1:0]  b_r;
    logic [NB_OP-1:0]    op_r;
    logic [NB_DATA-1:0]  result_r;
    logic [NB_TIMEOUT-1:0] tmo_cnt_r;

    logic                pop_s;
    logic                push_s;
    logic                expire_s;
    logic [NB_DATA-1:0]  alu_s;
    logic                op_valid_s;

    // Next-state decode and FIFO strobes; a pop always wins over timeout expiry.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            S_GET_A: begin
                if (!i_rx_empty) begin
                    pop_s        = 1'b1;
                    state_next_s = S_GET_B;
                end else begin
                    state_next_s = S_GET_A;
                end
            end
            S_GET_B: begin
                if (!i_rx_empty) begin
                    pop_s        = 1'b1;
                    state_next_s = S_GET_OP;
                end else if (tmo_cnt_r == TMO_MAX) begin
                    expire_s     = 1'b1;
                    state_next_s = S_GET_A;
                end else begin
                    state_next_s = S_GET_B;
                end
            end
            S_GET_OP: begin
                if (!i_rx_empty) begin
                    pop_s        = 1'b1;
                    state_next_s = S_EXEC;
                end else if (tmo_cnt_r == TMO_MAX) begin
                    expire_s     = 1'b1;
                    state_next_s = S_GET_A;
                end else begin
                    state_next_s = S_GET_OP;
                end
            end
            S_EXEC: begin
                state_next_s = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_full) begin
                    push_s       = 1'b1;
                    state_next_s = S_GET_A;
                end else begin
                    state_next_s = S_SEND;
                end
            end
            default: begin
                state_next_s = S_GET_A;
            end
        endcase
    end

    // ALU; shifts use the whole of B so oversize shifts saturate naturally.
    always_comb begin
        alu_s      = '0;
        op_valid_s = 1'b1;
        case (op_r)
            OP_ADD:  alu_s = a_r + b_r;
            OP_SUB:  alu_s = a_r - b_r;
            OP_AND:  alu_s = a_r & b_r;
            OP_OR:   alu_s = a_r | b_r;
            OP_XOR:  alu_s = a_r ^ b_r;
            OP_NOR:  alu_s = ~(a_r | b_r);
            OP_SRA:  alu_s = $unsigned($signed(a_r) >>> b_r);
            OP_SRL:  alu_s = a_r >> b_r;
            default: begin
                alu_s      = '0;
                op_valid_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= S_GET_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/opcode capture on each pop and result capture in S_EXEC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            result_r <= '0;
        end else begin
            if (pop_s && (state_r == S_GET_A)) begin
                a_r <= i_data_to_read;
            end
            if (pop_s && (state_r == S_GET_B)) begin
                b_r <= i_data_to_read;
            end
            if (pop_s && (state_r == S_GET_OP)) begin
                op_r <= i_data_to_read[NB_OP-1:0];
            end
            if (state_r == S_EXEC) begin
                result_r <= alu_s;
            end
        end
    end

    // Idle counter: only runs while a frame is partially received.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt_r <= '0;
        end else if (pop_s || expire_s) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == S_GET_B) || (state_r == S_GET_OP)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Strobes must coincide with the FIFO flags of the same cycle, so they are
    // decoded from the state register and forced low while reset is applied.
    assign o_read_uart     = pop_s & ~i_reset;
    assign o_write_uart    = push_s & ~i_reset;
    assign o_data_to_write = i_reset ? '0 : result_r;
    assign o_busy          = (state_r != S_GET_A) & ~i_reset;
    assign o_op_error      = (state_r == S_EXEC) & ~op_valid_s & ~i_reset;
    assign o_timeout       = expire_s & ~i_reset;

endmodule

// File: doc/uart_alu_bridge.md
UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, the width of data bytes and ALU operands.
REQ-002 SHALL have parameter NB_OP, default 6, the number of opcode bits taken from the low bits of the opcode byte.
REQ-003 SHALL have parameter TIMEOUT_LIMIT, default 1000000, the number of idle cycles allowed inside a partial frame.
REQ-004 SHALL have parameter NB_TIMEOUT, default 20, the width of the timeout counter.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_rx_empty, input, 1 bit: RX FIFO empty flag.
REQ-008 SHALL have port i_data_to_read, input, NB_DATA bits: RX FIFO head byte, valid while i_rx_empty=0.
REQ-009 SHALL have port o_read_uart, output, 1 bit: one-cycle pop strobe to the RX FIFO.
REQ-010 SHALL have port i_tx_full, input, 1 bit: TX FIFO full flag.
REQ-011 SHALL have port o_write_uart, output, 1 bit: one-cycle push strobe to the TX FIFO.
REQ-012 SHALL have port o_data_to_write, output, NB_DATA bits: result byte, valid while o_write_uart=1.
REQ-013 SHALL have port o_busy, output, 1 bit: high in any state other than S_GET_A.
REQ-014 SHALL have port o_op_error, output, 1 bit: one-cycle pulse when an unsupported opcode executes.
REQ-015 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-016 SHALL treat a frame as three RX bytes in order: operand A, operand B, opcode; the response is exactly one TX byte, the result.
REQ-017 SHALL implement the states S_GET_A, S_GET_B, S_GET_OP, S_EXEC and S_SEND; there are no other reachable states.
REQ-018 SHALL, in each S_GET_* state with i_rx_empty=0, capture i_data_to_read, assert o_read_uart for that single cycle, and advance to the next state.
REQ-019 SHALL stay in an S_GET_* state with o_read_uart=0 while i_rx_empty=1.
REQ-020 SHALL support back-to-back pops on consecutive cycles, so a full frame already in the FIFO is consumed in 3 cycles.
REQ-021 SHALL, in S_EXEC, spend exactly one cycle registering the result, then go to S_SEND.
REQ-022 SHALL support these opcodes (opcode byte [NB_OP-1:0]):
- ADD 0x20: A+B mod 2^NB_DATA.
- SUB 0x22: A-B mod 2^NB_DATA.
- AND 0x24, OR 0x25, XOR 0x26: bitwise.
- NOR 0x27: ~(A|B).
- SRA 0x03: A arithmetic-shifted right by B.
- SRL 0x02: A logic-shifted right by B.
REQ-023 SHALL use the full value of B as the shift amount; for B>=NB_DATA, SRL yields 0 and SRA yields all bits equal to A[NB_DATA-1].
REQ-024 SHALL ignore opcode bits above NB_OP-1.
REQ-025 SHALL, for an unsupported opcode, produce result 0x00 and pulse o_op_error in the S_EXEC cycle; the result byte is still sent.
REQ-026 SHALL, in S_SEND, hold with o_write_uart=0 while i_tx_full=1.
REQ-027 SHALL, in S_SEND with i_tx_full=0, assert o_write_uart for exactly one cycle with o_data_to_write=result, then return to S_GET_A.
REQ-028 SHALL never assert o_read_uart during S_EXEC or S_SEND.
REQ-029 SHALL drive o_data_to_write from the registered result, stable from S_EXEC until the next S_EXEC.
REQ-030 SHALL, in S_GET_B and S_GET_OP, increment the timeout counter each cycle that i_rx_empty=1 and clear it on every pop and on entry to S_GET_A.
REQ-031 SHALL, when the counter reaches TIMEOUT_LIMIT-1, discard the partial frame, pulse o_timeout for one cycle, and return to S_GET_A.
REQ-032 SHALL give a pop priority over timeout expiry when both occur in the same cycle.
REQ-033 SHALL not run the timeout in S_GET_A, S_EXEC or S_SEND.

Reset
REQ-034 SHALL, on i_reset=1 at a clock edge, enter S_GET_A and clear A, B, opcode, result and the timeout counter to 0.
REQ-035 SHALL hold o_read_uart, o_write_uart, o_busy, o_op_error and o_timeout at 0 and o_data_to_write at 0x00 while in reset.
REQ-036 SHALL, when reset occurs mid-frame or in S_SEND, drop the partial frame or pending result without a TX write, and leave FIFO contents not yet popped in place.

Verification
REQ-037 SHALL verify: RX 0x05, 0x03, 0x20 -> one write of 0x08; 3 pops total; o_busy returns to 0.
REQ-038 SHALL verify: RX 0x03, 0x05, 0x22 -> 0xFE; RX 0x80, 0x02, 0x03 -> 0xE0; RX 0x80, 0x02, 0x02 -> 0x20; RX 0x81, 0x09, 0x03 -> 0xFF.
REQ-039 SHALL verify: RX 0xAA, 0x55, 0x3F -> write of 0x00 and one o_op_error pulse; RX 0x0F, 0xF0, 0xE5 (bits above NB_OP ignored, so OR) -> 0xFF.
REQ-040 SHALL verify: i_tx_full=1 for 10 cycles in S_SEND -> no write and no pops; after release, exactly one write occurs on the next cycle.
REQ-041 SHALL verify, with TIMEOUT_LIMIT=16: RX 0x11 only, then 16 idle cycles -> o_timeout pulse and no write; then RX 0x01, 0x02, 0x20 -> 0x03.
REQ-042 SHALL verify: i_reset asserted after operand B is popped -> no write, state S_GET_A; the next full frame is computed correctly.
